led_pattern_controller: RTL

- Parametrised next-generation LED controller: a switch-selected rate divider drives an N-bit LED pattern engine with four selectable patterns.
- Adds pause (HOLD), pattern selection and deterministic reload on mode change; exports the rate tick as mode_clock.
- Sits between board switches and the LED bank; the whole design runs on a single clock domain.

---
 rtl/led_ctrl_pkg.sv | 38 +++
 rtl/led_pattern_controller_tick_divider.sv | 55 +++++
 rtl/led_pattern_controller.sv | 101 ++++++++++
 3 files changed

// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - shared encodings and seed values for the LED pattern controller
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        PAT_RUN    = 2'd0,
        PAT_BOUNCE = 2'd1,
        PAT_COUNT  = 2'd2,
        PAT_FILL   = 2'd3
    } pattern_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    typedef enum logic {
        PH_FILL  = 1'b0,
        PH_EMPTY = 1'b1
    } phase_t;

    localparam logic [1:0] SPD_STOP = 2'd0;

    localparam int unsigned SEED_RUN    = 1;
    localparam int unsigned SEED_BOUNCE = 1;
    localparam int unsigned SEED_COUNT  = 0;
    localparam int unsigned SEED_FILL   = 0;

    // Reload value loaded into the LED bank when a pattern is (re)selected
    function automatic int unsigned seed_of(input pattern_t pat);
        case (pat)
            PAT_RUN:    return SEED_RUN;
            PAT_BOUNCE: return SEED_BOUNCE;
            PAT_COUNT:  return SEED_COUNT;
            default:    return SEED_FILL;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_controller_tick_divider.sv
// rtl/led_pattern_controller_tick_divider.sv - switch-selected rate divider producing the pattern tick
module tick_divider
    import led_ctrl_pkg::*;
#(
    parameter int CNT_W = 24,
    parameter int DIV1  = 1000,
    parameter int DIV2  = 500,
    parameter int DIV3  = 200
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic [1:0] SW,
    input  logic       HOLD,
    output logic       tick
);

    localparam logic [CNT_W-1:0] TERM1 = CNT_W'(DIV1 - 1);
    localparam logic [CNT_W-1:0] TERM2 = CNT_W'(DIV2 - 1);
    localparam logic [CNT_W-1:0] TERM3 = CNT_W'(DIV3 - 1);

    logic [1:0]       sw_q;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] term;

    // Terminal count chosen by the registered speed code
    always_comb begin
        term = TERM3;
        case (sw_q)
            2'd1:    term = TERM1;
            2'd2:    term = TERM2;
            default: term = TERM3;
        endcase
    end

    // Combinational so the top can register LD and mode_clock on the same edge
    assign tick = (SW == sw_q) && (sw_q != SPD_STOP) && !HOLD && (counter == term);

    // Speed-change clear, pause, and wrap of the period counter
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            sw_q    <= SPD_STOP;
            counter <= '0;
        end else if (SW != sw_q) begin
            sw_q    <= SW;
            counter <= '0;
        end else if (sw_q == SPD_STOP || HOLD) begin
            counter <= counter;
        end else if (counter == term) begin
            counter <= '0;
        end else begin
            counter <= counter + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_controller.sv
// rtl/led_pattern_controller.sv - LED pattern engine driven by a switch-selected rate tick
module led_pattern_controller
    import led_ctrl_pkg::*;
#(
    parameter int LED_W = 16,
    parameter int CNT_W = 24,
    parameter int DIV1  = 1000,
    parameter int DIV2  = 500,
    parameter int DIV3  = 200
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic [1:0]       SW,
    input  logic [1:0]       PATTERN,
    input  logic             HOLD,
    output logic [LED_W-1:0] LD,
    output logic             mode_clock
);

    logic             tick;
    pattern_t         pat_q;
    dir_t             dir;
    phase_t           phase;
    logic [LED_W-1:0] adv_ld;
    dir_t             adv_dir;
    phase_t           adv_phase;
    logic [LED_W-1:0] seed_ld;

    tick_divider #(
        .CNT_W (CNT_W),
        .DIV1  (DIV1),
        .DIV2  (DIV2),
        .DIV3  (DIV3)
    ) u_div (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .SW      (SW),
        .HOLD    (HOLD),
        .tick    (tick)
    );

    assign seed_ld = LED_W'(seed_of(pattern_t'(PATTERN)));

    // Next LED state, direction and phase if the current pattern advances one step
    always_comb begin
        adv_ld    = LD;
        adv_dir   = dir;
        adv_phase = phase;
        case (pat_q)
            PAT_RUN: begin
                adv_ld = {LD[LED_W-2:0], LD[LED_W-1]};
            end
            PAT_BOUNCE: begin
                // Turn around on the step that lands on an end bit, so each end shows once
                if (dir == DIR_LEFT) begin
                    adv_ld = LD << 1;
                    if (adv_ld[LED_W-1]) adv_dir = DIR_RIGHT;
                end else begin
                    adv_ld = LD >> 1;
                    if (adv_ld[0]) adv_dir = DIR_LEFT;
                end
            end
            PAT_COUNT: begin
                adv_ld = LD + LED_W'(1);
            end
            default: begin
                if (phase == PH_FILL) begin
                    adv_ld = {LD[LED_W-2:0], 1'b1};
                    if (&adv_ld) adv_phase = PH_EMPTY;
                end else begin
                    adv_ld = {LD[LED_W-2:0], 1'b0};
                    if (adv_ld == '0) adv_phase = PH_FILL;
                end
            end
        endcase
    end

    // Pattern reload has priority over a tick; mode_clock always mirrors the tick
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            LD         <= LED_W'(SEED_RUN);
            mode_clock <= 1'b0;
            pat_q      <= PAT_RUN;
            dir        <= DIR_LEFT;
            phase      <= PH_FILL;
        end else begin
            mode_clock <= tick;
            if (PATTERN != pat_q) begin
                pat_q <= pattern_t'(PATTERN);
                LD    <= seed_ld;
                if (PATTERN == PAT_BOUNCE) dir   <= DIR_LEFT;
                if (PATTERN == PAT_FILL)   phase <= PH_FILL;
            end else if (tick) begin
                LD    <= adv_ld;
                dir   <= adv_dir;
                phase <= adv_phase;
            end
        end
    end

endmodule
